// File: rtl/bsg_manycore_cache_pkt_responder_if.sv
// Request/response bundle between the link-to-cache adapter (master) and the
// cache-side responder (slave). Packet layout, MSB first: {opcode[5:0], addr, data, mask}.
interface bsg_manycore_cache_pkt_responder_if #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 32
);
    localparam int pkt_width_lp = 6 + addr_width_p + data_width_p + data_width_p / 8;

    // Request: cache_pkt_i/v_i offered, yumi_o accepts it in the same cycle.
    // Response: data_o/v_o offered, yumi_i consumes it (only while v_o=1).
    logic [pkt_width_lp-1:0] cache_pkt_i;
    logic                    v_i;
    logic                    yumi_o;
    logic [data_width_p-1:0] data_o;
    logic                    v_o;
    logic                    yumi_i;
    logic                    v_we_o;

    modport master (
        output cache_pkt_i, v_i, yumi_i,
        input  yumi_o, data_o, v_o, v_we_o
    );

    modport slave (
        input  cache_pkt_i, v_i, yumi_i,
        output yumi_o, data_o, v_o, v_we_o
    );
endinterface

// File: rtl/bsg_manycore_cache_pkt_responder.sv
// Two-stage (tl, tv) behavioural cache stand-in over a flat word memory.
// Every memory access happens when a request moves tl -> tv, so ops complete in order.
module bsg_manycore_cache_pkt_responder #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 32,
    parameter int mem_els_p    = 1024
) (
    input logic clk_i,
    input logic reset_i,
    bsg_manycore_cache_pkt_responder_if.slave link
);
    localparam int mask_w_lp = data_width_p / 8;
    localparam int lg_els_lp = $clog2(mem_els_p);
    localparam int pkt_w_lp  = 6 + addr_width_p + data_width_p + mask_w_lp;

    localparam logic [5:0] OP_TAGST       = 6'b000000;
    localparam logic [5:0] OP_TAGFL       = 6'b000001;
    localparam logic [5:0] OP_TAGLA       = 6'b000010;
    localparam logic [5:0] OP_AFL         = 6'b000011;
    localparam logic [5:0] OP_AFLINV      = 6'b000100;
    localparam logic [5:0] OP_AINV        = 6'b000101;
    localparam logic [5:0] OP_LB          = 6'b010000;
    localparam logic [5:0] OP_LH          = 6'b010001;
    localparam logic [5:0] OP_LW          = 6'b010010;
    localparam logic [5:0] OP_LBU         = 6'b010100;
    localparam logic [5:0] OP_LHU         = 6'b010101;
    localparam logic [5:0] OP_SW          = 6'b011010;
    localparam logic [5:0] OP_SM          = 6'b011100;
    localparam logic [5:0] OP_AMOSWAP_W   = 6'b100000;
    localparam logic [5:0] OP_AMOADD_W    = 6'b100001;
    localparam logic [5:0] OP_AMOOR_W     = 6'b100100;
    localparam logic [5:0] OP_UNCACHED_LW = 6'b110010;
    localparam logic [5:0] OP_UNCACHED_SW = 6'b111010;

    if (data_width_p != 32) begin : g_bad_width
        $error("bsg_manycore_cache_pkt_responder: only data_width_p=32 is supported");
    end
    if (mem_els_p < 2 || (mem_els_p & (mem_els_p - 1)) != 0) begin : g_bad_els
        $error("bsg_manycore_cache_pkt_responder: mem_els_p must be a power of two >= 2");
    end

    logic [5:0]              in_op;
    logic [addr_width_p-1:0] in_addr;
    logic [data_width_p-1:0] in_data;
    logic [mask_w_lp-1:0]    in_mask;
    assign in_op   = link.cache_pkt_i[pkt_w_lp-1 -: 6];
    assign in_addr = link.cache_pkt_i[mask_w_lp+data_width_p +: addr_width_p];
    assign in_data = link.cache_pkt_i[mask_w_lp +: data_width_p];
    assign in_mask = link.cache_pkt_i[mask_w_lp-1:0];

    // tl keeps only the address bits that matter: word index and byte offset.
    logic                    tl_v_q;
    logic [5:0]              tl_op_q;
    logic [lg_els_lp-1:0]    tl_idx_q;
    logic [1:0]              tl_off_q;
    logic [data_width_p-1:0] tl_data_q;
    logic [mask_w_lp-1:0]    tl_mask_q;
    logic                    tv_v_q;
    logic [data_width_p-1:0] tv_data_q;
    logic [data_width_p-1:0] mem_q [mem_els_p];

    logic tl_adv;
    logic accept;
    assign tl_adv = ~reset_i & tl_v_q & (~tv_v_q | link.yumi_i);
    assign accept = ~reset_i & link.v_i & (~tl_v_q | tl_adv);

    assign link.yumi_o = accept;
    assign link.v_we_o = tl_adv;
    assign link.v_o    = tv_v_q;
    assign link.data_o = tv_data_q;

    logic [data_width_p-1:0] word;
    logic [15:0]             half;
    logic [7:0]              byte_sel;
    logic [data_width_p-1:0] rdata;
    logic [data_width_p-1:0] wdata;
    logic                    we;
    logic                    op_known;

    assign word     = mem_q[tl_idx_q];
    assign half     = word[{tl_off_q[1], 4'b0000} +: 16];
    assign byte_sel = word[{tl_off_q, 3'b000} +: 8];

    always_comb begin
        rdata    = '0;
        wdata    = word;
        we       = 1'b0;
        op_known = 1'b1;
        case (tl_op_q)
            OP_LW, OP_UNCACHED_LW: rdata = word;
            OP_LH:  rdata = {{16{half[15]}}, half};
            OP_LHU: rdata = {16'b0, half};
            OP_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: rdata = {24'b0, byte_sel};
            OP_SW, OP_UNCACHED_SW: begin
                we    = 1'b1;
                wdata = tl_data_q;
            end
            OP_SM: begin
                we = 1'b1;
                for (int i = 0; i < mask_w_lp; i++) begin
                    if (tl_mask_q[i]) wdata[8*i +: 8] = tl_data_q[8*i +: 8];
                end
            end
            OP_AMOSWAP_W: begin
                rdata = word;
                we    = 1'b1;
                wdata = tl_data_q;
            end
            OP_AMOADD_W: begin
                rdata = word;
                we    = 1'b1;
                wdata = word + tl_data_q;
            end
            OP_AMOOR_W: begin
                rdata = word;
                we    = 1'b1;
                wdata = word | tl_data_q;
            end
            OP_TAGST, OP_TAGFL, OP_TAGLA, OP_AFL, OP_AFLINV, OP_AINV: rdata = '0;
            default: op_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tl_v_q    <= 1'b0;
            tv_v_q    <= 1'b0;
            tv_data_q <= '0;
        end else begin
            if (accept) begin
                tl_v_q    <= 1'b1;
                tl_op_q   <= in_op;
                tl_idx_q  <= in_addr[2 +: lg_els_lp];
                tl_off_q  <= in_addr[1:0];
                tl_data_q <= in_data;
                tl_mask_q <= in_mask;
            end else if (tl_adv) begin
                tl_v_q <= 1'b0;
            end

            if (tl_adv) begin
                tv_v_q    <= 1'b1;
                tv_data_q <= rdata;
            end else if (link.yumi_i) begin
                tv_v_q <= 1'b0;
            end

            if (tl_adv && !op_known) begin
                $error("bsg_manycore_cache_pkt_responder: unsupported opcode %b", tl_op_q);
            end
        end
    end

    // Memory is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (tl_adv && we) mem_q[tl_idx_q] <= wdata;
    end
endmodule

// File: doc/bsg_manycore_cache_pkt_responder.md
Name: bsg_manycore_cache_pkt_responder

Overview:
- Behavioural responder for the bsg_cache_pkt request/response interface, i.e. the cache-side end of the manycore link-to-cache adapter.
- Accepts bsg_cache_pkt requests, executes them against an internal flat word memory (no tags, no DMA), and returns data in order.
- Pipeline is two stages (tl, tv) and emits v_we_o exactly when a request moves from tl to tv, so the adapter's tl/tv info tracking stays aligned.
- Used as a fast cache stand-in in testbenches and small tiles.

Parameters:
addr_width_p, 28, byte address width of cache_pkt addr field.
data_width_p, 32, data word width; only 32 is supported (elaboration error otherwise).
mem_els_p, 1024, number of data words in backing memory; power of two, at least 2.

Ports:
clk_i  input  1  clock.
reset_i  input  1  synchronous, active-high reset.
cache_pkt_i  input  `bsg_cache_pkt_width(addr_width_p,data_width_p)  request {opcode, addr, data, mask}.
v_i  input  1  request valid.
yumi_o  output  1  request accepted this cycle.
data_o  output  data_width_p  response data.
v_o  output  1  response valid.
yumi_i  input  1  response consumed; only legal when v_o=1.
v_we_o  output  1  the tl entry advances to tv this cycle.

Behaviour:
- Reset values: v_o=0, yumi_o=0, v_we_o=0, data_o=0. Both stages are emptied and in-flight requests are discarded. Memory contents are not cleared.
- Reset mid-operation: requests in tl/tv are dropped with no response; the first accept can occur in the cycle after reset deasserts.
- Stage tl holds valid bit tl_v_r and the registered packet.
- Stage tv holds valid bit tv_v_r and the result word; v_o=tv_v_r, data_o=tv result.
- tl_adv = tl_v_r & (~tv_v_r | yumi_i). v_we_o = tl_adv.
- yumi_o = v_i & (~tl_v_r | tl_adv). yumi_o depends combinationally on v_i and yumi_i.
- Latency: a request accepted in cycle N reaches tl in N+1. With tv empty it advances (v_we_o=1) in N+1, and v_o=1 in N+2.
- Throughput: one request per cycle under continuous yumi_i.
- Memory execution: every read and write happens at the tl_adv edge. Ops therefore execute strictly in order and there is no RAW hazard between back-to-back requests.
- Word index = addr[2 +: log2(mem_els_p)]. Upper address bits are ignored, so addresses alias modulo the memory size.
- Loads:
  - LW and UNCACHED_LW return the word.
  - LH and LHU select the halfword by addr[1]; LB and LBU select the byte by addr[1:0].
  - Signed loads sign-extend; unsigned loads zero-extend.
- Stores:
  - SM writes the byte lanes where mask bit i=1.
  - SW and UNCACHED_SW write the full word regardless of mask.
  - Stores return 0.
- AMOs: AMOSWAP_W, AMOADD_W (32-bit wraparound add) and AMOOR_W return the old word and write the new value in the same tl_adv.
- No-ops returning 0: TAGST, TAGLA, TAGFL, AFL, AFLINV, AINV. Memory is unchanged.
- Any other opcode behaves as a no-op returning 0 and triggers a simulation $error.
- Boundary cases:
  - tv full with yumi_i=0: tl holds and yumi_o=0 if tl is full.
  - Simultaneous yumi_i and new accept: tv refills from tl and tl refills from input in the same cycle with no bubble.
  - v_i=0 with tl empty: nothing happens and v_we_o=0.
- Responses return in request order; exactly one response per accepted request.

Test Plan:
- Reset, then issue 64 TAGST (addr k<<5), yumi_i=1 always -> 64 responses of 0. The first v_we_o comes one cycle after the first yumi_o; v_o then follows one cycle later.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10, LH 0x12, LHU 0x12, LB 0x13, LBU 0x11 -> 0, 0xDEADBEEF, 0xFFFFDEAD, 0x0000DEAD, 0xFFFFFFDE, 0x000000BE.
- SM addr 0x20 data 0x11223344 mask 4'b0101 over prior 0xAAAAAAAA, then LW -> 0xAA22AA44.
- AMOADD_W addr 0x30 data 5 over prior 0xFFFFFFFE -> returns 0xFFFFFFFE. A following LW returns 0x00000003. AMOSWAP_W 7 -> returns 3. AMOOR_W 8 -> returns 7. LW -> 0xF.
- Back-pressure: hold yumi_i=0 for 5 cycles with v_i=1 -> at most 2 accepts, v_we_o=0 once tv is full. Release -> all responses arrive in order with no loss or duplication. Address mem_els_p*4+0x10 aliases to 0x10.
- Assert reset_i with both stages full -> v_o=0 next cycle and no stale response afterward. A subsequent LW still returns the previously stored memory value.
